// File: rtl/mem_arbiter_if.sv
// Refill-port bundle between both caches, the arbiter and memory.
// slave is the arbiter's view, master is the environment's view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              ic_valid_req_i;
    logic [ADDR_W-1:0] ic_addr_i;
    logic              ic_ready_o;
    logic [LINE_W-1:0] ic_data_o;
    logic              dc_valid_req_i;
    logic              dc_we_i;
    logic [ADDR_W-1:0] dc_addr_i;
    logic [LINE_W-1:0] dc_wdata_i;
    logic              dc_ready_o;
    logic [LINE_W-1:0] dc_data_o;
    logic              mem_valid_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_wdata_o;
    logic              mem_ready_i;
    logic [LINE_W-1:0] mem_data_i;
    logic [1:0]        grant_o;
    logic              err_o;

    modport slave (
        input  ic_valid_req_i, ic_addr_i,
        input  dc_valid_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
        input  mem_ready_i, mem_data_i,
        output ic_ready_o, ic_data_o, dc_ready_o, dc_data_o,
        output mem_valid_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output grant_o, err_o
    );

    modport master (
        output ic_valid_req_i, ic_addr_i,
        output dc_valid_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
        output mem_ready_i, mem_data_i,
        input  ic_ready_o, ic_data_o, dc_ready_o, dc_data_o,
        input  mem_valid_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  grant_o, err_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the shared 128-bit refill port (Icache / Dcache).
// One memory transaction in flight; responses routed back to the owner.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t            state_q, state_d;
    logic              ic_pend, dc_pend;
    logic [ADDR_W-1:0] ic_addr, dc_addr;
    logic              dc_we;
    logic [LINE_W-1:0] dc_wdata;
    logic              rr_dc;
    logic [CNT_W-1:0]  cnt;
    logic              gnt_ic, gnt_dc, done;

    logic              mem_v, mem_we, ic_rdy, dc_rdy, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata, ic_data, dc_data;
    logic [1:0]        grant;

    assign bus.mem_valid_req_o = mem_v;
    assign bus.mem_we_o        = mem_we;
    assign bus.mem_addr_o      = mem_addr;
    assign bus.mem_wdata_o     = mem_wdata;
    assign bus.ic_ready_o      = ic_rdy;
    assign bus.ic_data_o       = ic_data;
    assign bus.dc_ready_o      = dc_rdy;
    assign bus.dc_data_o       = dc_data;
    assign bus.grant_o         = grant;
    assign bus.err_o           = err;

    always_comb begin
        state_d = state_q;
        gnt_ic  = 1'b0;
        gnt_dc  = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ic_pend && (!dc_pend || rr_dc)) gnt_ic = 1'b1;
                else if (dc_pend)                   gnt_dc = 1'b1;
                if (gnt_ic || gnt_dc) state_d = WAIT_MEM;
            end
            WAIT_MEM: begin
                if (bus.mem_ready_i) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // A new pulse beats the grant clearing the same flag; a pulse while still pending is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            ic_pend  <= 1'b0;
            ic_addr  <= '0;
            dc_pend  <= 1'b0;
            dc_addr  <= '0;
            dc_we    <= 1'b0;
            dc_wdata <= '0;
        end else begin
            if (bus.ic_valid_req_i && (!ic_pend || gnt_ic)) begin
                ic_pend <= 1'b1;
                ic_addr <= {bus.ic_addr_i[ADDR_W-1:4], 4'b0};
            end else if (gnt_ic) begin
                ic_pend <= 1'b0;
            end
            if (bus.dc_valid_req_i && (!dc_pend || gnt_dc)) begin
                dc_pend  <= 1'b1;
                dc_addr  <= {bus.dc_addr_i[ADDR_W-1:4], 4'b0};
                dc_we    <= bus.dc_we_i;
                dc_wdata <= bus.dc_wdata_i;
            end else if (gnt_dc) begin
                dc_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_v     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ic_rdy    <= 1'b0;
            ic_data   <= '0;
            dc_rdy    <= 1'b0;
            dc_data   <= '0;
            grant     <= 2'b00;
            err       <= 1'b0;
            rr_dc     <= 1'b1;
            cnt       <= '0;
        end else begin
            mem_v  <= gnt_ic || gnt_dc;
            ic_rdy <= 1'b0;
            dc_rdy <= 1'b0;
            if (gnt_ic) begin
                mem_we    <= 1'b0;
                mem_addr  <= ic_addr;
                mem_wdata <= '0;
                grant     <= 2'b01;
                cnt       <= '0;
            end
            if (gnt_dc) begin
                mem_we    <= dc_we;
                mem_addr  <= dc_addr;
                mem_wdata <= dc_wdata;
                grant     <= 2'b10;
                cnt       <= '0;
            end
            if (state_q == WAIT_MEM) begin
                if (done) begin
                    if (grant[0]) begin
                        ic_rdy  <= 1'b1;
                        ic_data <= bus.mem_data_i;
                    end
                    if (grant[1]) begin
                        dc_rdy <= 1'b1;
                        if (!mem_we) dc_data <= bus.mem_data_i;
                    end
                    rr_dc <= grant[1];
                    grant <= 2'b00;
                    cnt   <= '0;
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    err <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule
